hack_screen_fetch: RTL and testbench

Pixel-fetch stage that feeds the VGA video mux. It converts the VGA timing generator's CounterX/CounterY into Hack screen-RAM word reads on the memory's video port. It serialises each 16-bit word into pixels, Hack order: bit 0 is the leftmost pixel and 1 is black. It outputs a registered RGB pixel plus sync/active signals delayed to match, replacing the combinational hack_pos/hack_pixel path in the top level.

---
 rtl/hack_video_pkg.sv | 11 +
 rtl/hack_screen_fetch_if.sv | 13 +
 rtl/hack_pixel_shifter.sv | 21 ++
 rtl/hack_screen_fetch.sv | 80 ++++++++
 tb/tb_hack_screen_fetch.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/hack_video_pkg.sv
// hack_video_pkg: shared VGA/Hack screen geometry constants
package hack_video_pkg;
    localparam int H_ACTIVE      = 640;
    localparam int V_ACTIVE      = 480;
    localparam int HACK_W        = 512;
    localparam int HACK_H        = 256;
    localparam int WORD_W        = 16;
    localparam int WORDS_PER_ROW = HACK_W / WORD_W;
    localparam int WIN_X0        = 64;
    localparam int WIN_Y0        = 40;
endpackage

// File: rtl/hack_screen_fetch_if.sv
// hack_screen_fetch_if: screen-RAM video read port (address out, word back)
interface hack_screen_fetch_if
    import hack_video_pkg::*;
#(
    parameter int VADDR_W = 13
);
    logic [VADDR_W-1:0] vaddr;
    logic               vreq;
    logic [WORD_W-1:0]  vdata;

    modport master (output vaddr, output vreq, input vdata);
    modport slave  (input vaddr, input vreq, output vdata);
endinterface

// File: rtl/hack_pixel_shifter.sv
// hack_pixel_shifter: 16-bit word serialiser, bit 0 out first, load beats shift
module hack_pixel_shifter
    import hack_video_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              lsb
);
    logic [WORD_W-1:0] sh;

    // load a fresh word, otherwise move the next pixel into bit 0
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)      sh <= '0;
        else if (load)  sh <= din;
        else if (shift) sh <= {1'b0, sh[WORD_W-1:1]};

    assign lsb = sh[0];
endmodule

// File: rtl/hack_screen_fetch.sv
// hack_screen_fetch: turns VGA counters into screen-RAM reads and registered pixels
module hack_screen_fetch
    import hack_video_pkg::*;
#(
    parameter int          X0      = WIN_X0,
    parameter int          Y0      = WIN_Y0,
    parameter int          RD_LAT  = 1,
    parameter int          VADDR_W = 13,
    parameter logic [23:0] FG      = 24'h000000,
    parameter logic [23:0] BG      = 24'hFFFFFF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [9:0]                 counter_x,
    input  logic [9:0]                 counter_y,
    input  logic                       hs_in,
    input  logic                       vs_in,
    input  logic                       da_in,
    hack_screen_fetch_if.master        vbus,
    output logic                       pixel,
    output logic                       in_win,
    output logic [23:0]                rgb,
    output logic                       hs_out,
    output logic                       vs_out,
    output logic                       da_out
);
    logic [10:0]        dx, dy, p;
    logic               in_rows, win, fetch, load, bit0;
    logic [RD_LAT-1:0]  vpipe;
    logic [VADDR_W-1:0] vaddr;

    // offsets wrap to large values left of / above the window, so one compare bounds both sides
    assign dx      = {1'b0, counter_x} - 11'(X0);
    assign dy      = {1'b0, counter_y} - 11'(Y0);
    assign p       = {1'b0, counter_x} + 11'(1 + RD_LAT) - 11'(X0);
    assign in_rows = dy < 11'(HACK_H);
    assign win     = in_rows && dx < 11'(HACK_W);
    assign fetch   = in_rows && p < 11'(HACK_W) && p[3:0] == 4'd0;
    assign load    = vpipe[RD_LAT-1];

    // issue word reads ahead of each 16-pixel group; vpipe tracks when vdata is valid
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            vaddr <= '0;
            vpipe <= '0;
        end else begin
            vpipe <= RD_LAT'({vpipe, fetch});
            if (fetch) vaddr <= VADDR_W'({dy[7:0], p[8:4]});
        end

    assign vbus.vaddr = vaddr;
    assign vbus.vreq  = vpipe[0];

    hack_pixel_shifter u_shift (
        .clk   (clk),
        .rstn  (rstn),
        .load  (load),
        .shift (win && !load),
        .din   (vbus.vdata),
        .lsb   (bit0)
    );

    // one register stage for pixel, colour and syncs so they stay aligned
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            pixel  <= 1'b0;
            in_win <= 1'b0;
            rgb    <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            da_out <= 1'b0;
        end else begin
            pixel  <= win && bit0;
            in_win <= win;
            rgb    <= win ? (bit0 ? FG : BG) : 24'h0;
            hs_out <= hs_in;
            vs_out <= vs_in;
            da_out <= da_in;
        end
endmodule

// File: tb/tb_hack_screen_fetch.sv
// tb_hack_screen_fetch: directed checks of fetch timing, pixel order and sync alignment
module tb_hack_screen_fetch;
    logic        clk = 1'b0, rstn = 1'b0;
    logic [9:0]  counter_x = '0, counter_y = '0;
    logic        hs_in = 1'b0, vs_in = 1'b0, da_in = 1'b0;
    logic        pixel1, in_win1, hs1, vs1, da1;
    logic        pixel2, in_win2, hs2, vs2, da2;
    logic [23:0] rgb1, rgb2;
    logic [15:0] mem [0:8191];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    hack_screen_fetch_if #(.VADDR_W(13)) bus1 ();
    hack_screen_fetch_if #(.VADDR_W(13)) bus2 ();

    assign bus1.vdata = mem[bus1.vaddr];
    always @(posedge clk) bus2.vdata <= mem[bus2.vaddr];

    hack_screen_fetch #(.RD_LAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .counter_x(counter_x), .counter_y(counter_y),
        .hs_in(hs_in), .vs_in(vs_in), .da_in(da_in), .vbus(bus1),
        .pixel(pixel1), .in_win(in_win1), .rgb(rgb1),
        .hs_out(hs1), .vs_out(vs1), .da_out(da1)
    );

    hack_screen_fetch #(.RD_LAT(2)) dut2 (
        .clk(clk), .rstn(rstn), .counter_x(counter_x), .counter_y(counter_y),
        .hs_in(hs_in), .vs_in(vs_in), .da_in(da_in), .vbus(bus2),
        .pixel(pixel2), .in_win(in_win2), .rgb(rgb2),
        .hs_out(hs2), .vs_out(vs2), .da_out(da2)
    );

    // present (x,y) for one cycle; afterwards the registered outputs describe that cycle
    task automatic step(input int x, input int y);
        counter_x = 10'(x);
        counter_y = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] w;
        logic        ep;
        logic [23:0] er;
        rstn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hs_in = i[0];
            vs_in = i[1];
            da_in = 1'b1;
            step(60 + i, 40);
            total++;
            if ({bus1.vaddr, bus1.vreq, pixel1, in_win1, rgb1, hs1, vs1, da1} !== '0) begin
                bad++;
                $display("FAIL reset_outputs x=%0d got vaddr=%0d vreq=%b pix=%b win=%b rgb=%h hs=%b vs=%b da=%b want all 0",
                         60 + i, bus1.vaddr, bus1.vreq, pixel1, in_win1, rgb1, hs1, vs1, da1);
            end
        end
        hs_in = 1'b0; vs_in = 1'b0; da_in = 1'b0;
        w = 16'hA5C3;
        mem[323] = w;
        rstn = 1'b1;
        for (int x = 100; x < 128; x++) begin
            step(x, 50);
            ep = (x < 112) ? 1'b0 : w[x - 112];
            er = ep ? 24'h000000 : 24'hFFFFFF;
            total++;
            if (pixel1 !== ep || rgb1 !== er) begin
                bad++;
                $display("FAIL reset_release x=%0d got pix=%b rgb=%h want pix=%b rgb=%h", x, pixel1, rgb1, ep, er);
            end
        end
    endtask

    task automatic test_single_word();
        logic ep;
        mem[0] = 16'h0001;
        for (int x = 56; x < 100; x++) begin
            step(x, 40);
            if (x == 62 || x == 63) begin
                total++;
                if (bus1.vreq !== (x == 62) || bus1.vaddr !== 13'd0) begin
                    bad++;
                    $display("FAIL single_fetch x=%0d got vreq=%b vaddr=%0d want vreq=%b vaddr=0", x, bus1.vreq, bus1.vaddr, x == 62);
                end
            end
            if (x >= 64 && x <= 79) begin
                ep = (x == 64);
                total++;
                if (pixel1 !== ep || rgb1 !== (ep ? 24'h000000 : 24'hFFFFFF) || in_win1 !== 1'b1) begin
                    bad++;
                    $display("FAIL single_pixel x=%0d got pix=%b rgb=%h win=%b want pix=%b", x, pixel1, rgb1, in_win1, ep);
                end
            end
        end
    endtask

    task automatic test_row_addr();
        step(558, 41);
        total++;
        if (bus1.vreq !== 1'b1 || bus1.vaddr !== 13'd63) begin
            bad++;
            $display("FAIL row_addr_41 got vreq=%b vaddr=%0d want 1/63", bus1.vreq, bus1.vaddr);
        end
        step(558, 295);
        total++;
        if (bus1.vreq !== 1'b1 || bus1.vaddr !== 13'd8191) begin
            bad++;
            $display("FAIL row_addr_last got vreq=%b vaddr=%0d want 1/8191", bus1.vreq, bus1.vaddr);
        end
        step(558, 296);
        total++;
        if (bus1.vreq !== 1'b0 || bus1.vaddr !== 13'd8191) begin
            bad++;
            $display("FAIL row_addr_below got vreq=%b vaddr=%0d want 0/8191", bus1.vreq, bus1.vaddr);
        end
    endtask

    task automatic test_word_boundary();
        logic ep;
        mem[32] = 16'hFFFF;
        mem[33] = 16'h0000;
        mem[34] = 16'h0000;
        for (int x = 56; x < 100; x++) begin
            step(x, 41);
            if (x == 63) begin
                total++;
                if (in_win1 !== 1'b0 || in_win2 !== 1'b0) begin
                    bad++;
                    $display("FAIL boundary_left_edge got win1=%b win2=%b want 0", in_win1, in_win2);
                end
            end
            if (x >= 64 && x <= 95) begin
                ep = (x < 80);
                total++;
                if (pixel1 !== ep || pixel2 !== ep) begin
                    bad++;
                    $display("FAIL boundary_pixel x=%0d got pix1=%b pix2=%b want %b", x, pixel1, pixel2, ep);
                end
            end
        end
    endtask

    task automatic test_rd_lat2();
        logic ep;
        mem[0] = 16'h0001;
        for (int x = 56; x < 90; x++) begin
            step(x, 40);
            if (x == 61 || x == 62) begin
                total++;
                if (bus2.vreq !== (x == 61) || bus2.vaddr !== 13'd0) begin
                    bad++;
                    $display("FAIL lat2_fetch x=%0d got vreq=%b vaddr=%0d want vreq=%b vaddr=0", x, bus2.vreq, bus2.vaddr, x == 61);
                end
            end
            if (x >= 64 && x <= 79) begin
                ep = (x == 64);
                total++;
                if (pixel2 !== ep || rgb2 !== (ep ? 24'h000000 : 24'hFFFFFF)) begin
                    bad++;
                    $display("FAIL lat2_pixel x=%0d got pix=%b rgb=%h want pix=%b", x, pixel2, rgb2, ep);
                end
            end
        end
    endtask

    task automatic test_sync();
        hs_in = 1'b0;
        step(655, 50);
        total++;
        if (hs1 !== 1'b0) begin
            bad++;
            $display("FAIL sync_before got hs=%b want 0", hs1);
        end
        hs_in = 1'b1;
        step(656, 50);
        total++;
        if (hs1 !== 1'b1 || hs2 !== 1'b1) begin
            bad++;
            $display("FAIL sync_pulse got hs1=%b hs2=%b want 1", hs1, hs2);
        end
        hs_in = 1'b0;
        vs_in = 1'b1;
        da_in = 1'b1;
        step(657, 50);
        total++;
        if (hs1 !== 1'b0 || vs1 !== 1'b1 || da1 !== 1'b1) begin
            bad++;
            $display("FAIL sync_after got hs=%b vs=%b da=%b want 0/1/1", hs1, vs1, da1);
        end
        vs_in = 1'b0;
        da_in = 1'b0;
        step(658, 50);
        total++;
        if (vs1 !== 1'b0 || da1 !== 1'b0) begin
            bad++;
            $display("FAIL sync_clear got vs=%b da=%b want 0/0", vs1, da1);
        end
    endtask

    task automatic test_outside();
        int xs [3] = '{10, 600, 100};
        int ys [3] = '{50, 50, 300};
        for (int i = 0; i < 3; i++) begin
            step(xs[i], ys[i]);
            total++;
            if (in_win1 !== 1'b0 || rgb1 !== 24'h0 || bus1.vreq !== 1'b0 || pixel1 !== 1'b0) begin
                bad++;
                $display("FAIL outside x=%0d y=%0d got win=%b rgb=%h vreq=%b pix=%b want all 0",
                         xs[i], ys[i], in_win1, rgb1, bus1.vreq, pixel1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        #1;
        test_reset();
        test_single_word();
        test_row_addr();
        test_word_boundary();
        test_rd_lat2();
        test_sync();
        test_outside();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
